// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: buffers unsigned 8-bit operand pairs in a small FIFO,
// streams them into an external MAC_unit (A, B, clear), and returns the
// 16-bit dot product of every LEN pairs on a result channel.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid && ready are both high. Once out_valid is raised it stays high,
// with out_sum unchanged, until that transfer. in_ready is a pure function of
// FIFO fullness and never depends on in_valid.
module mac_dot_sequencer #(
  parameter int LEN   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  output logic        mac_clr,
  input  logic [15:0] mac_s,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [15:0]   r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [7:0]    r_mac_a;
  logic [7:0]    r_mac_b;
  logic          r_mac_clr;
  logic          r_out_valid;
  logic [15:0]   r_out_sum;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_rd_data;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Full blocks a push even when a pop happens on the same edge.
  assign w_push    = in_valid && !w_full;
  assign w_pop     = (r_state == S_RUN) && !w_empty;
  assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  assign in_ready  = !w_full;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign mac_clr   = r_mac_clr;
  assign busy      = (r_state != S_DONE) && (!w_empty || (r_count != '0));
  assign dbg_state = r_state;

  // FIFO storage: data only, no reset needed since pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_a, in_b};
    end
  end

  // FIFO pointers: reset empties the buffer, dropping any pending pairs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Sequencer FSM: clear MAC, feed LEN pairs, wait two edges for the MAC
  // to absorb the last product, then present the result until accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_CLEAR;
      r_count     <= '0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_clr   <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          // MAC zeroes on this edge because mac_clr is still high.
          r_mac_clr <= 1'b0;
          r_mac_a   <= '0;
          r_mac_b   <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (w_pop) begin
            r_mac_a <= w_rd_data[15:8];
            r_mac_b <= w_rd_data[7:0];
            if (r_count == CW'(LEN - 1)) begin
              r_count <= '0;
              r_state <= S_DRAIN1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end else begin
            // Starved cycle: feed zeros so the MAC adds nothing.
            r_mac_a <= '0;
            r_mac_b <= '0;
          end
        end
        S_DRAIN1: begin
          // The last pair is still on mac_a/mac_b and is added on this edge.
          r_mac_a <= '0;
          r_mac_b <= '0;
          r_state <= S_DRAIN2;
        end
        S_DRAIN2: begin
          r_mac_a     <= '0;
          r_mac_b     <= '0;
          r_out_sum   <= mac_s;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_mac_clr   <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        default: begin
          r_mac_clr   <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Testbench for mac_dot_sequencer with a behavioural MAC_unit attached.
module tb_mac_dot_sequencer;

  localparam int LEN   = 4;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_clr;
  logic [15:0] mac_s;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];

  // Scenario-1 operands: sum 73895 mod 65536 = 0x20A7
  logic [7:0] va [4] = '{8'd15, 8'd40, 8'd47, 8'd255};
  logic [7:0] vb [4] = '{8'd17, 8'd45, 8'd145, 8'd255};
  // Latency operands: 2+12+30+56 = 100
  logic [7:0] la [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
  logic [7:0] lb [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
  // Push/pop overlap operands: first four sum 0x763F, last four 0x16E8
  logic [7:0] qa [8] = '{8'd3, 8'd10, 8'd200, 8'd7, 8'd9, 8'd100, 8'd255, 8'd1};
  logic [7:0] qb [8] = '{8'd5, 8'd20, 8'd150, 8'd8, 8'd11, 8'd50, 8'd2, 8'd255};

  mac_dot_sequencer #(.LEN(LEN), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr   (mac_clr),
    .mac_s     (mac_s),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural MAC_unit
  always @(posedge clock) begin
    if (mac_clr) mac_s <= 16'h0000;
    else         mac_s <= mac_s + 16'(mac_a) * 16'(mac_b);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic rdy);
    @(negedge clock);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = rdy;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Called at a negedge; presents one pair for exactly one rising edge.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clock);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_sum, mac_a, mac_b, mac_clr, busy, in_ready, dbg_state} !==
        {1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got ov=%b sum=%h a=%h b=%h clr=%b busy=%b rdy=%b st=%0d want ov=0 sum=0000 a=00 b=00 clr=1 busy=0 rdy=1 st=0",
               out_valid, out_sum, mac_a, mac_b, mac_clr, busy, in_ready, dbg_state);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit ok;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push_pair(va[i], vb[i]);
    wait_out_valid(20, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_timeout: out_valid=0 want 1 within 20 cycles");
    end
    n_cmp++;
    if (out_sum !== 16'h20A7) begin
      n_fail++;
      $display("FAIL b2b_sum: got %h want 20a7", out_sum);
    end
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_one_cycle: got ov=%b busy=%b want ov=0 busy=0", out_valid, busy);
    end
  endtask

  task automatic test_latency;
    logic       exp_ov;
    logic       exp_clr;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    do_reset(1'b1);
    n_cmp++;
    if (mac_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_clear_cycle: got mac_clr=%b want 1", mac_clr);
    end
    for (int e = 1; e <= 8; e++) begin
      if (e <= 4) begin
        in_valid = 1'b1;
        in_a     = la[e-1];
        in_b     = lb[e-1];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
      exp_ov  = (e == 7);
      exp_clr = (e == 8);
      exp_a   = (e >= 2 && e <= 5) ? la[e-2] : 8'h00;
      exp_b   = (e >= 2 && e <= 5) ? lb[e-2] : 8'h00;
      n_cmp++;
      if (out_valid !== exp_ov || mac_clr !== exp_clr) begin
        n_fail++;
        $display("FAIL lat_edge%0d_ctl: got ov=%b clr=%b want ov=%b clr=%b",
                 e, out_valid, mac_clr, exp_ov, exp_clr);
      end
      n_cmp++;
      if (mac_a !== exp_a || mac_b !== exp_b) begin
        n_fail++;
        $display("FAIL lat_edge%0d_mac: got a=%h b=%h want a=%h b=%h",
                 e, mac_a, mac_b, exp_a, exp_b);
      end
      if (e == 7) begin
        n_cmp++;
        if (out_sum !== 16'd100) begin
          n_fail++;
          $display("FAIL lat_sum: got %h want 0064", out_sum);
        end
      end
    end
  endtask

  task automatic test_gaps;
    bit ok;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = va[i];
      in_b     = vb[i];
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (mac_a !== va[i] || mac_b !== vb[i]) begin
        n_fail++;
        $display("FAIL gap_load%0d: got a=%h b=%h want a=%h b=%h", i, mac_a, mac_b, va[i], vb[i]);
      end
      @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (mac_a !== 8'h00 || mac_b !== 8'h00) begin
        n_fail++;
        $display("FAIL gap_zero%0d: got a=%h b=%h want a=00 b=00", i, mac_a, mac_b);
      end
    end
    wait_out_valid(20, ok);
    n_cmp++;
    if (!ok || out_sum !== 16'h20A7) begin
      n_fail++;
      $display("FAIL gap_sum: got ov=%b sum=%h want ov=1 sum=20a7", ok, out_sum);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) push_pair(va[i], vb[i]);
    wait_out_valid(20, ok);
    n_cmp++;
    if (!ok || out_sum !== 16'h20A7) begin
      n_fail++;
      $display("FAIL bp_first: got ov=%b sum=%h want ov=1 sum=20a7", ok, out_sum);
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        in_valid = 1'b1;
        in_a     = 8'd1;
        in_b     = 8'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== 16'h20A7) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got ov=%b sum=%h want ov=1 sum=20a7", c, out_valid, out_sum);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got in_ready=%b busy=%b want in_ready=0 busy=0", in_ready, busy);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || mac_clr !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b clr=%b busy=%b want ov=0 clr=1 busy=1", out_valid, mac_clr, busy);
    end
    wait_out_valid(20, ok);
    n_cmp++;
    if (!ok || out_sum !== 16'h0004) begin
      n_fail++;
      $display("FAIL bp_second: got ov=%b sum=%h want ov=1 sum=0004", ok, out_sum);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset(1'b1);
    push_pair(va[0], vb[0]);
    push_pair(va[1], vb[1]);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_sum, mac_a, mac_b, mac_clr, busy, in_ready, dbg_state} !==
        {1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_values: got ov=%b sum=%h a=%h b=%h clr=%b busy=%b rdy=%b st=%0d want ov=0 sum=0000 a=00 b=00 clr=1 busy=0 rdy=1 st=0",
               out_valid, out_sum, mac_a, mac_b, mac_clr, busy, in_ready, dbg_state);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) push_pair(8'd2, 8'd3);
    wait_out_valid(20, ok);
    n_cmp++;
    if (!ok || out_sum !== 16'h0018) begin
      n_fail++;
      $display("FAIL mid_sum: got ov=%b sum=%h want ov=1 sum=0018", ok, out_sum);
    end
  endtask

  task automatic test_simul_push_pop;
    bit ok;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) push_pair(va[i], vb[i]);
    wait_out_valid(20, ok);
    for (int i = 0; i < 3; i++) push_pair(qa[i], qb[i]);
    n_cmp++;
    if (!ok || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_three: got ov=%b in_ready=%b want ov=1 in_ready=1", ok, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    for (int k = 3; k <= 6; k++) begin
      in_valid = 1'b1;
      in_a     = qa[k];
      in_b     = qb[k];
      @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (in_ready !== 1'b1 || mac_a !== qa[k-3] || mac_b !== qb[k-3]) begin
        n_fail++;
        $display("FAIL pp_overlap%0d: got in_ready=%b a=%h b=%h want in_ready=1 a=%h b=%h",
                 k, in_ready, mac_a, mac_b, qa[k-3], qb[k-3]);
      end
    end
    push_pair(qa[7], qb[7]);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_full: got in_ready=%b want 0", in_ready);
    end
    wait_out_valid(20, ok);
    n_cmp++;
    if (!ok || out_sum !== 16'h763F) begin
      n_fail++;
      $display("FAIL pp_sum1: got ov=%b sum=%h want ov=1 sum=763f", ok, out_sum);
    end
    out_ready = 1'b1;
    @(posedge clock);
    wait_out_valid(20, ok);
    n_cmp++;
    if (!ok || out_sum !== 16'h16E8) begin
      n_fail++;
      $display("FAIL pp_sum2: got ov=%b sum=%h want ov=1 sum=16e8", ok, out_sum);
    end
  endtask

  task automatic test_random_stream;
    localparam int NV = 20;
    logic [15:0] acc;
    logic [15:0] exp_v;
    int cnt;
    int pushed;
    int got;
    acc    = '0;
    cnt    = 0;
    pushed = 0;
    got    = 0;
    exp_q.delete();
    do_reset(1'b0);
    for (int cyc = 0; cyc < 3000 && got < NV; cyc++) begin
      if (pushed < NV * LEN) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = 8'($urandom_range(0, 255));
        in_b     = 8'($urandom_range(0, 255));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        acc = acc + 16'(in_a) * 16'(in_b);
        cnt++;
        pushed++;
        if (cnt == LEN) begin
          exp_q.push_back(acc);
          acc = '0;
          cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_unexpected: got sum=%h want no result", out_sum);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_sum !== exp_v) begin
            n_fail++;
            $display("FAIL rnd_sum%0d: got %h want %h", got, out_sum, exp_v);
          end
        end
      end
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (got != NV) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d results want %0d", got, NV);
    end
  endtask

  // Test sequence and final report
  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_latency();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    test_simul_push_pop();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
